muldiv_ctrl: RTL and testbench

Sequencer for the CPU's iterative multiply and divide units. Accepts MULT/DIV requests from the main control unit and launches the selected unit with one-cycle `init` pulses. Counts the unit's fixed latency, then commits its result into architectural HI/LO registers, which it owns. Also handles MFHI/MFLO/MTHI/MTLO access, divide-by-zero, abort, and the pipeline stall while a unit is running.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_cnt.sv | 36 +++
 rtl/muldiv_ctrl.sv | 142 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the multiply/divide sequencer.
// State encoding, default unit latencies and the datapath word width.
package muldiv_pkg;

    localparam int WORD            = 32;
    localparam int MULT_CYCLES_DEF = 33;
    localparam int DIV_CYCLES_DEF  = 35;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MRUN = 2'd1,
        DRUN = 2'd2,
        ZERO = 2'd3
    } muldiv_state_t;

    function automatic int cnt_width(input int m, input int d);
        int mx;
        mx = (m > d) ? m : d;
        return (mx > 1) ? $clog2(mx) : 1;
    endfunction

endpackage

// File: rtl/muldiv_cnt.sv
// muldiv_cnt: loadable latency down-counter with a zero flag.
// Saturates at zero so it never wraps while a unit is idle.
module muldiv_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: launches the iterative multiply/divide units, counts their
// latency and commits results into the architectural HI/LO registers.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_mult,
    input  logic            start_div,
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    input  logic            abort,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [WORD-1:0] wdata,
    input  logic            rd_hi,
    input  logic            rd_lo,
    input  logic [WORD-1:0] mult_hi,
    input  logic [WORD-1:0] mult_lo,
    input  logic [WORD-1:0] div_hi,
    input  logic [WORD-1:0] div_lo,
    output logic [WORD-1:0] unit_a,
    output logic [WORD-1:0] unit_b,
    output logic            mult_init,
    output logic            div_init,
    output logic            unit_stop,
    output logic [WORD-1:0] hi,
    output logic [WORD-1:0] lo,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic            div0_exc
);

    localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

    muldiv_state_t   state_q;
    logic [WORD-1:0] ua_q, ub_q, hi_q, lo_q;
    logic            minit_q, dinit_q, stop_q;
    logic            busy_q, done_q, div0_q;

    logic            idle_w, run_w, wr_ok;
    logic            acc_mult, acc_div, acc_zero;
    logic            kill, commit;
    logic            cnt_load, cnt_zero;
    logic [CW-1:0]   cnt_val;

    // Multiply wins a simultaneous request; abort outranks the commit.
    always_comb begin
        idle_w   = (state_q == IDLE);
        run_w    = (state_q == MRUN) || (state_q == DRUN);
        wr_ok    = (state_q == IDLE) || (state_q == ZERO);
        acc_mult = idle_w & start_mult;
        acc_div  = idle_w & ~start_mult & start_div & (b != '0);
        acc_zero = idle_w & ~start_mult & start_div & (b == '0);
        kill     = run_w & abort;
        commit   = run_w & ~abort & cnt_zero;
        cnt_load = acc_mult | acc_div;
        cnt_val  = acc_mult ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
    end

    muldiv_cnt #(
        .W (CW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (run_w),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ua_q    <= '0;
            ub_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            minit_q <= 1'b0;
            dinit_q <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            minit_q <= acc_mult;
            dinit_q <= acc_div;
            stop_q  <= kill;
            done_q  <= commit;
            div0_q  <= acc_zero;
            if (cnt_load) begin
                ua_q <= a;
                ub_q <= b;
            end
            if (wr_ok && wr_hi) hi_q <= wdata;
            if (wr_ok && wr_lo) lo_q <= wdata;
            unique case (state_q)
                IDLE: begin
                    if (acc_mult) begin
                        state_q <= MRUN;
                        busy_q  <= 1'b1;
                    end else if (acc_div) begin
                        state_q <= DRUN;
                        busy_q  <= 1'b1;
                    end else if (acc_zero) begin
                        state_q <= ZERO;
                    end
                end
                MRUN, DRUN: begin
                    if (kill || commit) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    if (commit) begin
                        hi_q <= (state_q == MRUN) ? mult_hi : div_hi;
                        lo_q <= (state_q == MRUN) ? mult_lo : div_lo;
                    end
                end
                ZERO: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign unit_a    = ua_q;
    assign unit_b    = ub_q;
    assign mult_init = minit_q;
    assign div_init  = dinit_q;
    assign unit_stop = stop_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div0_exc  = div0_q;
    assign stall     = busy_q &
                       (start_mult | start_div | wr_hi | wr_lo | rd_hi | rd_lo);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and randomized checks of the muldiv sequencer
// against behavioural unit models and an arithmetic HI/LO reference.
module tb_muldiv_ctrl;

    localparam int MC = 33;
    localparam int DC = 35;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_mult, start_div, abort;
    logic        wr_hi, wr_lo, rd_hi, rd_lo;
    logic [31:0] a, b, wdata;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
    logic [31:0] unit_a, unit_b, hi, lo;
    logic        mult_init, div_init, unit_stop;
    logic        busy, stall, done, div0_exc;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_hi, exp_lo;
    int mcyc, dcyc;

    always #5 clk = ~clk;

    muldiv_ctrl #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .abort      (abort),
        .wr_hi      (wr_hi),
        .wr_lo      (wr_lo),
        .wdata      (wdata),
        .rd_hi      (rd_hi),
        .rd_lo      (rd_lo),
        .mult_hi    (mult_hi),
        .mult_lo    (mult_lo),
        .div_hi     (div_hi),
        .div_lo     (div_lo),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .mult_init  (mult_init),
        .div_init   (div_init),
        .unit_stop  (unit_stop),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .div0_exc   (div0_exc)
    );

    function automatic logic [63:0] mul_ref(input logic [31:0] x,
                                            input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p;
    endfunction

    function automatic logic [63:0] div_ref(input logic [31:0] x,
                                            input logic [31:0] y);
        int sx, sy, q, r;
        sx = x;
        sy = y;
        q  = sx / sy;
        r  = sx % sy;
        return {r, q};
    endfunction

    // Unit models: results are garbage until their latency has elapsed.
    always @(posedge clk) begin
        if (!rst || unit_stop) mcyc <= 0;
        else if (mult_init) mcyc <= 1;
        else if (mcyc != 0 && mcyc < 1000) mcyc <= mcyc + 1;
        if (!rst || unit_stop) dcyc <= 0;
        else if (div_init) dcyc <= 1;
        else if (dcyc != 0 && dcyc < 1000) dcyc <= dcyc + 1;
    end

    always_comb begin
        {mult_hi, mult_lo} = 64'hBAD0_BAD1_BAD2_BAD3;
        {div_hi, div_lo}   = 64'hDEAD_0001_DEAD_0002;
        if (mcyc != 0 && mcyc >= MC - 1)
            {mult_hi, mult_lo} = mul_ref(unit_a, unit_b);
        if (dcyc != 0 && dcyc >= DC - 1 && unit_b != 0)
            {div_hi, div_lo} = div_ref(unit_a, unit_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // kind: 0 mult, 1 div, 2 both strobes (mult must win)
    task automatic run_op(input int kind, input logic [31:0] oa,
                          input logic [31:0] ob, input logic [31:0] eh,
                          input logic [31:0] el, input int abort_at,
                          input bit hold, input bit wr_start,
                          input logic [31:0] wd);
        int n;
        bit is_div;
        is_div     = (kind == 1);
        n          = is_div ? DC : MC;
        start_mult = !is_div;
        start_div  = (kind != 0);
        a          = oa;
        b          = ob;
        if (wr_start) begin
            wr_hi = 1'b1;
            wdata = wd;
        end
        tick();
        start_mult = 1'b0;
        start_div  = 1'b0;
        wr_hi      = 1'b0;
        if (wr_start) exp_hi = wd;
        if (is_div && ob == 0) begin
            chk("div0_exc", 32'(div0_exc), 1);
            chk("div0_busy", 32'(busy), 0);
            chk("div0_init", 32'(div_init), 0);
            chk("div0_hi", hi, exp_hi);
            chk("div0_lo", lo, exp_lo);
            tick();
            chk("div0_clr", 32'(div0_exc), 0);
            chk("div0_busy2", 32'(busy), 0);
            chk("div0_init2", 32'(div_init), 0);
            return;
        end
        chk("acc_busy", 32'(busy), 1);
        chk("acc_minit", 32'(mult_init), 32'(!is_div));
        chk("acc_dinit", 32'(div_init), 32'(is_div));
        chk("acc_ua", unit_a, oa);
        chk("acc_ub", unit_b, ob);
        chk("acc_hi", hi, exp_hi);
        if (hold) begin
            rd_hi = 1'b1;
            wr_lo = 1'b1;
            wdata = wd;
        end
        for (int k = 1; k <= n; k++) begin
            if (hold) chk("run_stall", 32'(stall), 1);
            if (k == abort_at) abort = 1'b1;
            tick();
            abort = 1'b0;
            if (k == abort_at) begin
                rd_hi = 1'b0;
                wr_lo = 1'b0;
                chk("abt_stop", 32'(unit_stop), 1);
                chk("abt_busy", 32'(busy), 0);
                chk("abt_done", 32'(done), 0);
                chk("abt_hi", hi, exp_hi);
                chk("abt_lo", lo, exp_lo);
                tick();
                chk("abt_stop2", 32'(unit_stop), 0);
                chk("abt_done2", 32'(done), 0);
                chk("abt_hi2", hi, exp_hi);
                return;
            end
            if (k < n) begin
                chk("run_done", 32'(done), 0);
                chk("run_busy", 32'(busy), 1);
                if (k == 1) chk("run_init", 32'(mult_init | div_init), 0);
            end
        end
        exp_hi = eh;
        exp_lo = el;
        chk("cmt_done", 32'(done), 1);
        chk("cmt_busy", 32'(busy), 0);
        chk("cmt_hi", hi, exp_hi);
        chk("cmt_lo", lo, exp_lo);
        chk("cmt_stop", 32'(unit_stop), 0);
        if (hold) begin
            chk("cmt_stall", 32'(stall), 0);
            tick();
            exp_lo = wd;
            chk("post_wr_lo", lo, exp_lo);
            chk("post_done", 32'(done), 0);
            rd_hi = 1'b0;
            wr_lo = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] r;
        int kind, ab, gap;
        logic [31:0] ra, rb, rw;
        rst = 1'b0;
        {start_mult, start_div, abort} = '0;
        {wr_hi, wr_lo, rd_hi, rd_lo}   = '0;
        a = '0; b = '0; wdata = '0;
        exp_hi = '0;
        exp_lo = '0;
        tick();
        tick();
        rd_lo = 1'b1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_ua", unit_a, 0);
        chk("rst_ub", unit_b, 0);
        chk("rst_ctl", {25'b0, mult_init, div_init, unit_stop,
                        done, div0_exc, busy, stall}, 0);
        rd_lo = 1'b0;
        rst = 1'b1;
        tick();

        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_stop", 32'(unit_stop), 0);
        chk("idle_abort_busy", 32'(busy), 0);

        run_op(1, 100, 7, 2, 14, 0, 0, 0, 0);
        run_op(0, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 0, 0);
        run_op(1, 55, 0, 0, 0, 0, 0, 0, 0);
        run_op(1, 1000, 3, 1, 333, 10, 0, 0, 0);
        run_op(0, 9, 9, 0, 81, MC, 0, 0, 0);
        run_op(0, 3, 4, 0, 12, 0, 1, 0, 32'h1234);
        run_op(1, 40, 6, 4, 6, 0, 0, 1, 32'hCAFE_0001);

        start_div = 1'b1;
        a = 50;
        b = 5;
        tick();
        start_div = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        chk("mrst_hi", hi, 0);
        chk("mrst_lo", lo, 0);
        chk("mrst_ua", unit_a, 0);
        chk("mrst_ctl", {26'b0, mult_init, div_init, unit_stop,
                         done, div0_exc, busy}, 0);
        exp_hi = '0;
        exp_lo = '0;
        rst = 1'b1;
        run_op(2, 6, 7, 0, 42, 0, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            kind = int'($urandom_range(0, 4));
            if (kind > 2) kind = kind - 3;
            ra = $urandom;
            rb = $urandom;
            if (kind == 1 && $urandom_range(0, 4) == 0) rb = 0;
            if (kind == 1 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 3;
            if (kind == 1 && rb != 0) r = div_ref(ra, rb);
            else r = mul_ref(ra, rb);
            ab = 0;
            if ($urandom_range(0, 3) == 0)
                ab = int'($urandom_range(1, (kind == 1) ? DC : MC));
            rw = $urandom;
            run_op(kind, ra, rb, r[63:32], r[31:0], ab, 0,
                   ($urandom_range(0, 3) == 0), rw);
            gap = int'($urandom_range(0, 2));
            repeat (gap) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
